// File: rtl/otp_cipher_stream.sv
// otp_cipher_stream: one-time-pad cipher stage with valid/ready streaming.
// Encrypt XORs the data with a fresh LFSR pad and stores that pad in the next
// slot; decrypt XORs the data with a stored pad picked by index. The result
// sits in a 1-deep output register until the consumer takes it.
// Optional build macro OTP_ONE_TIME_EN enables one-time enforcement: each pad
// may be consumed once, refused requests raise out_err, and pad_full reports
// that the next encrypt slot still holds an unconsumed pad.

module otp_cipher_stream #(
  parameter int          DATA_W    = 8,
  parameter int          PAD_DEPTH = 8,
  parameter logic [31:0] LFSR_SEED = 32'hBDCA2C92,
  localparam int         IDX_W     = $clog2(PAD_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_decrypt,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_err,
  output logic              pad_full
);

  logic [31:0]       lfsr;
  logic              lfsr_fb;
  logic [IDX_W-1:0]  wr_ptr;
  logic [DATA_W-1:0] pads [PAD_DEPTH];
  logic [DATA_W-1:0] pad;
  logic              accept;

  logic [DATA_W-1:0] res_data;
  logic [IDX_W-1:0]  res_idx;
  logic              res_err;
  logic              do_store;

`ifdef OTP_ONE_TIME_EN
  logic [PAD_DEPTH-1:0] used;
  logic                 do_clear;
`endif

  // The output register can take a new result when empty or when it is being
  // drained in the same cycle.
  assign in_ready = en & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  // The pad is the low bits of the LFSR before it advances.
  assign pad     = lfsr[DATA_W-1:0];
  assign lfsr_fb = ~(~(~(lfsr[31] ^ lfsr[21]) ^ lfsr[1]) ^ lfsr[0]);

`ifdef OTP_ONE_TIME_EN
  assign pad_full = used[wr_ptr];
`else
  assign pad_full = 1'b0;
`endif

  // Result of the request currently presented, plus which store update it implies.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value held, which would infer a latch.
    res_data = '0;
    res_idx  = wr_ptr;
    res_err  = 1'b0;
    do_store = 1'b0;
`ifdef OTP_ONE_TIME_EN
    do_clear = 1'b0;
`endif
    if (in_decrypt) begin
      res_idx = in_idx;
`ifdef OTP_ONE_TIME_EN
      if (!used[in_idx]) begin
        res_err = 1'b1;
      end else begin
        res_data = in_data ^ pads[in_idx];
        do_clear = 1'b1;
      end
`else
      res_data = in_data ^ pads[in_idx];
`endif
    end else begin
`ifdef OTP_ONE_TIME_EN
      if (pad_full) begin
        res_err = 1'b1;
      end else begin
        res_data = in_data ^ pad;
        do_store = 1'b1;
      end
`else
      res_data = in_data ^ pad;
      do_store = 1'b1;
`endif
    end
  end

  // Output register: load on accept, empty on drain, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= res_data;
      out_idx   <= res_idx;
      out_err   <= res_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // LFSR and write pointer advance only when a pad is actually issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr   <= LFSR_SEED;
      wr_ptr <= '0;
    end else if (accept && do_store) begin
      lfsr   <= {lfsr[30:0], lfsr_fb};
      wr_ptr <= wr_ptr + IDX_W'(1);
    end
  end

  // Pad store: written on encrypt, zeroized on a consuming decrypt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the pad store is small and must read as zero after reset, so it is reset like ordinary flops.
      for (int i = 0; i < PAD_DEPTH; i++) pads[i] <= '0;
    end else if (accept && do_store) begin
      pads[wr_ptr] <= pad;
`ifdef OTP_ONE_TIME_EN
    end else if (accept && do_clear) begin
      pads[in_idx] <= '0;
`endif
    end
  end

`ifdef OTP_ONE_TIME_EN
  // Slot occupancy: set when a pad is stored, cleared when it is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      used <= '0;
    end else if (accept && do_store) begin
      used[wr_ptr] <= 1'b1;
    end else if (accept && do_clear) begin
      used[in_idx] <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_otp_cipher_stream.sv
// Testbench for otp_cipher_stream (DATA_W=8, PAD_DEPTH=8, default seed).
// A reference model built from pad lists and slot flags predicts every cycle;
// directed tables and sequences cover reset, backpressure, wrap, enable and
// asynchronous reset. Works with or without OTP_ONE_TIME_EN.

module tb_otp_cipher_stream;

`ifdef OTP_ONE_TIME_EN
  localparam bit ONE_TIME = 1'b1;
`else
  localparam bit ONE_TIME = 1'b0;
`endif

  logic       clk, rst_n, en, in_valid, in_ready, in_decrypt;
  logic [2:0] in_idx, out_idx;
  logic [7:0] in_data, out_data;
  logic       out_valid, out_ready, out_err, pad_full;

  int tests  = 0;
  int failed = 0;

  otp_cipher_stream dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_valid(in_valid), .in_ready(in_ready), .in_decrypt(in_decrypt),
    .in_idx(in_idx), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_err(out_err), .pad_full(pad_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_lfsr;
  int          m_wr;
  logic [7:0]  m_pads [8];
  bit          m_used [8];
  bit          m_valid, m_err;
  logic [7:0]  m_data;
  int          m_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Feedback is the XNOR of taps 31, 21, 1, 0.
  function automatic logic [31:0] lfsr_next(input logic [31:0] q);
    logic fb;
    fb = ~(q[31] ^ q[21] ^ q[1] ^ q[0]);
    return (q << 1) | {31'd0, fb};
  endfunction

  task automatic model_reset();
    m_lfsr  = 32'hBDCA2C92;
    m_wr    = 0;
    m_valid = 0;
    m_err   = 0;
    m_data  = 8'h00;
    m_idx   = 0;
    for (int i = 0; i < 8; i++) begin
      m_pads[i] = 8'h00;
      m_used[i] = 0;
    end
  endtask

  task automatic model_accept(input bit dec, input int ix, input logic [7:0] d);
    m_valid = 1;
    m_err   = 0;
    if (dec) begin
      m_idx = ix;
      if (ONE_TIME && !m_used[ix]) begin
        m_err  = 1;
        m_data = 8'h00;
      end else begin
        m_data = d ^ m_pads[ix];
        if (ONE_TIME) begin
          m_pads[ix] = 8'h00;
          m_used[ix] = 0;
        end
      end
    end else begin
      m_idx = m_wr;
      if (ONE_TIME && m_used[m_wr]) begin
        m_err  = 1;
        m_data = 8'h00;
      end else begin
        m_data       = d ^ m_lfsr[7:0];
        m_pads[m_wr] = m_lfsr[7:0];
        m_used[m_wr] = 1;
        m_lfsr       = lfsr_next(m_lfsr);
        m_wr         = (m_wr + 1) % 8;
      end
    end
  endtask

  // One clock cycle: drive at edge+1, check in_ready mid-cycle, check outputs edge+1.
  task automatic cycle(input bit e, input bit v, input bit dec, input logic [2:0] ix,
                       input logic [7:0] d, input bit ordy);
    bit exp_rdy;
    en = e; in_valid = v; in_decrypt = dec; in_idx = ix; in_data = d; out_ready = ordy;
    #4;
    exp_rdy = e & (~m_valid | ordy);
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    @(posedge clk);
    #1;
    if (v && exp_rdy) model_accept(dec, int'(ix), d);
    else if (ordy) m_valid = 0;
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid) begin
      check("out_data", {24'd0, out_data}, {24'd0, m_data});
      check("out_idx", {29'd0, out_idx}, 32'(m_idx));
      check("out_err", {31'd0, out_err}, {31'd0, m_err});
    end
    check("pad_full", {31'd0, pad_full}, {31'd0, (ONE_TIME && m_used[m_wr])});
  endtask

  task automatic do_reset();
    en = 1'b0; in_valid = 1'b0; in_decrypt = 1'b0; in_idx = '0; in_data = '0; out_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    model_reset();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_idx", {29'd0, out_idx}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_pad_full", {31'd0, pad_full}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         en, v, dec;
    logic [2:0] idx;
    logic [7:0] data;
    bit         ordy;
    bit         e_valid;
    logic [7:0] e_data;
    logic [2:0] e_idx;
    bit         e_err;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    // en v dec idx data ordy | valid data idx err
    tbl[0] = '{1, 1, 0, 3'd0, 8'h00, 1, 1, 8'h92, 3'd0, 0};
    tbl[1] = '{1, 1, 1, 3'd0, 8'h92, 1, 1, 8'h00, 3'd0, 0};
`ifdef OTP_ONE_TIME_EN
    tbl[2] = '{1, 1, 1, 3'd0, 8'h92, 1, 1, 8'h00, 3'd0, 1};
    tbl[3] = '{1, 1, 1, 3'd5, 8'hA5, 1, 1, 8'h00, 3'd5, 1};
`else
    tbl[2] = '{1, 1, 1, 3'd0, 8'h92, 1, 1, 8'h00, 3'd0, 0};
    tbl[3] = '{1, 1, 1, 3'd5, 8'hA5, 1, 1, 8'hA5, 3'd5, 0};
`endif
    tbl[4] = '{1, 0, 0, 3'd0, 8'h00, 1, 0, 8'h00, 3'd0, 0};

    // Reset state and basic encrypt/decrypt vectors
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(tbl[i].en, tbl[i].v, tbl[i].dec, tbl[i].idx, tbl[i].data, tbl[i].ordy);
      check($sformatf("tbl%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_valid});
      if (tbl[i].e_valid) begin
        check($sformatf("tbl%0d_data", i), {24'd0, out_data}, {24'd0, tbl[i].e_data});
        check($sformatf("tbl%0d_idx", i), {29'd0, out_idx}, {29'd0, tbl[i].e_idx});
        check($sformatf("tbl%0d_err", i), {31'd0, out_err}, {31'd0, tbl[i].e_err});
      end
    end

    // Backpressure: held output stays frozen, then drain and accept together
    do_reset();
    cycle(1, 1, 0, 3'd0, 8'h00, 0);
    cycle(1, 1, 0, 3'd0, 8'h11, 0);
    check("bp_ready_low", {31'd0, in_ready}, 32'd0);
    check("bp_frozen_data", {24'd0, out_data}, 32'h92);
    cycle(1, 1, 1, 3'd0, 8'h92, 1);
    check("bp_drain_accept", {24'd0, out_data}, 32'h00);

    // Nine encrypts without decrypts: wrap behaviour
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 3'd0, 8'($urandom), 1);
`ifdef OTP_ONE_TIME_EN
    check("wrap_pad_full", {31'd0, pad_full}, 32'd1);
`else
    check("wrap_pad_full", {31'd0, pad_full}, 32'd0);
`endif
    cycle(1, 1, 0, 3'd0, 8'h3C, 1);
    check("wrap_idx", {29'd0, out_idx}, 32'd0);
`ifdef OTP_ONE_TIME_EN
    check("wrap_err", {31'd0, out_err}, 32'd1);
    check("wrap_data", {24'd0, out_data}, 32'd0);
`else
    check("wrap_err", {31'd0, out_err}, 32'd0);
`endif

    // Enable low blocks acceptance and does not step the LFSR
    do_reset();
    cycle(0, 1, 0, 3'd0, 8'h55, 1);
    check("en0_ready", {31'd0, in_ready}, 32'd0);
    cycle(1, 1, 0, 3'd0, 8'h00, 1);
    check("en0_first_pad", {24'd0, out_data}, 32'h92);

    // Asynchronous reset while a result is pending
    do_reset();
    cycle(1, 1, 0, 3'd0, 8'h00, 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_data", {24'd0, out_data}, 32'd0);
    do_reset();
    cycle(1, 1, 0, 3'd0, 8'h00, 1);
    check("post_rst_pad", {24'd0, out_data}, 32'h92);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 4) < 2,
            3'($urandom), 8'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
